led_scan_driver: RTL and testbench
==================================

Name: led_scan_driver

Overview:
Consumer end of the playfield framebuffer. The LED renderer writes a 64x64 1-bit frame; this block reads it back row-pair by row-pair and serialises it onto a 1/32-scan HUB75-style panel. It drives the panel shift clock, row address, latch and output-enable. It sits between the framebuffer read port and the top-level panel pins, in the sys_clock domain.

Parameters:
COLS, 64, pixels per row (shift length)
ROWS, 64, panel rows; scan rows = ROWS/2
CLK_DIV, 2, sys_clock cycles per panel_clk half-period (>=1)
ON_CYCLES, 256, sys_clock cycles oe_n held low per row

Ports:
sys_clock  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
enable  in  1  1 = scan continuously; 0 = finish current row, then idle blanked
fb_rd_en  out  1  framebuffer read strobe
fb_rd_row  out  6  framebuffer row being read
fb_rd_data  in  64  row data, valid exactly 1 cycle after fb_rd_en
panel_r1  out  1  upper-half pixel (row r)
panel_r2  out  1  lower-half pixel (row r+32)
panel_clk  out  1  shift clock; panel samples on rising edge
panel_lat  out  1  latch strobe, active high
panel_oe_n  out  1  output enable, active low
panel_addr  out  5  scan row address
frame_done  out  1  1-cycle pulse after row 31 display completes

Behaviour:
- Reset (and any cycle with reset=1, including mid-row): state=IDLE, row=0, fb_rd_en=0, fb_rd_row=0, panel_r1=panel_r2=0, panel_clk=0, panel_lat=0, panel_oe_n=1, panel_addr=0, frame_done=0, all counters 0.
- States: IDLE, FETCH, SHIFT, BLANK, LATCH, DISPLAY.
- IDLE: oe_n=1. If enable=1, go to FETCH next cycle.
- FETCH, 3 cycles:
  - c0: fb_rd_en=1, fb_rd_row=row.
  - c1: fb_rd_en=1, fb_rd_row=row+32; capture fb_rd_data into upper buffer.
  - c2: fb_rd_en=0; capture into lower buffer. Go to SHIFT.
- SHIFT: COLS column slots, each 2*CLK_DIV cycles.
  - Bit order: column 63 first, column 0 last.
  - Slot start: panel_r1/r2 update to the buffered bits and panel_clk=0 for CLK_DIV cycles, then panel_clk=1 for CLK_DIV cycles.
  - Data is stable across each rising edge.
  - After the last slot: panel_clk=0, go to BLANK.
- BLANK, 1 cycle: panel_oe_n=1, panel_addr<=row.
- LATCH: panel_lat=1 for CLK_DIV cycles, oe_n stays 1.
- DISPLAY: panel_oe_n=0 for ON_CYCLES cycles, then oe_n=1.
  - If row==31: row<=0 and pulse frame_done for 1 cycle.
  - Otherwise row<=row+1.
  - Next state: FETCH if enable=1, else IDLE.
- Row period = 3 + 2*CLK_DIV*COLS + 1 + CLK_DIV + ON_CYCLES cycles (518 at defaults).
- panel_oe_n is never low while panel_lat=1 or in BLANK. panel_addr changes only in BLANK.
- enable drop: sampled only at the end of DISPLAY; the current row always completes.
- row counter is 5 bits and wraps 31->0. fb_rd_row = {1'b0,row} or {1'b1,row}.
- fb_rd_data is ignored except in the two capture cycles; frame edits mid-shift take effect on the next fetch.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package led_panel_pkg: COLS/ROWS/SCAN_ROWS constants, state enum, row period function for the bench.
- One sub-module scan_shifter: holds the two 64-bit buffers and the column and phase counters, generates panel_clk/r1/r2, and raises shift_done. The parent FSM handles fetch, latch, display and addressing.

Test Plan:
- Reset, then enable=1 with a model framebuffer: fb_rd_row=0 then 32 on consecutive cycles, and panel_oe_n=1 until DISPLAY.
- Row 0 = 64'h8000_0000_0000_0001, row 32 = 0: first rising panel_clk sees r1=1, rising edges 2..63 see r1=0, edge 64 sees r1=1; r2=0 throughout; exactly 64 rising edges.
- Defaults: cycles from the row's first fb_rd_en to its oe_n rising = 518. panel_addr increments 0->1 only during BLANK. lat high 2 cycles with oe_n=1.
- Run 32 rows: frame_done pulses once, 32*518 cycles after start; next fetch reads rows 0/32 again (wrap).
- Deassert enable mid-SHIFT of row 5: row 5 completes through DISPLAY, then IDLE with oe_n=1 and no further fb_rd_en; reassert: fetch resumes at row 6.
- Assert reset during DISPLAY of row 10: next cycle all outputs are at reset values, and scanning restarts at row 0 when enable=1.

Source files
------------

// File: rtl/led_panel_pkg.sv
// Shared constants, scan FSM state type and row-timing helper for the LED panel scan driver.
package led_panel_pkg;

   localparam int unsigned COLS      = 64;
   localparam int unsigned ROWS      = 64;
   localparam int unsigned SCAN_ROWS = ROWS / 2;
   localparam int unsigned COL_W     = $clog2(COLS);
   localparam int unsigned ROW_W     = $clog2(SCAN_ROWS);
   localparam int unsigned FB_ROW_W  = $clog2(ROWS);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SHIFT,
      ST_BLANK,
      ST_LATCH,
      ST_DISPLAY
   } scan_state_e;

   // sys_clock cycles from a row's first read strobe to its output-enable release
   function automatic int unsigned row_period(input int unsigned clk_div,
                                              input int unsigned on_cycles);
      return 3 + 2 * clk_div * COLS + 1 + clk_div + on_cycles;
   endfunction

endpackage

// File: rtl/led_scan_driver_if.sv
// Framebuffer read port between the scan driver (master) and the frame store (slave).
interface led_scan_driver_if;
   import led_panel_pkg::*;

   logic                fb_rd_en;
   logic [FB_ROW_W-1:0] fb_rd_row;
   logic [COLS-1:0]     fb_rd_data;

   modport master (output fb_rd_en, output fb_rd_row, input  fb_rd_data);
   modport slave  (input  fb_rd_en, input  fb_rd_row, output fb_rd_data);

endinterface

// File: rtl/scan_shifter.sv
// Row-pair buffers and column/phase sequencing; serialises one row pair MSB first onto r1/r2/pclk.
module scan_shifter
   import led_panel_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load_hi,
   input  logic            load_lo,
   input  logic [COLS-1:0] data,
   output logic            r1,
   output logic            r2,
   output logic            pclk,
   output logic            shift_done
);

   localparam int unsigned SLOT = 2 * CLK_DIV;
   localparam int unsigned PH_W = (SLOT > 1) ? $clog2(SLOT) : 1;
   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SLOT - 1);
   localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(CLK_DIV);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

   logic [COLS-1:0]  upper, upper_d;
   logic [COLS-1:0]  lower, lower_d;
   logic [COL_W-1:0] col, col_d;
   logic [PH_W-1:0]  phase, phase_d;
   logic             active, active_d;
   logic [COL_W-1:0] idx;
   logic             r1_d, r2_d, pclk_d, done_d;

   // Loading the lower half starts slot 0; outputs are computed from next-cycle counters.
   always_comb begin
      upper_d  = upper;
      lower_d  = lower;
      col_d    = col;
      phase_d  = phase;
      active_d = active;
      if (load_hi) begin
         upper_d = data;
      end
      if (load_lo) begin
         lower_d  = data;
         active_d = 1'b1;
         col_d    = '0;
         phase_d  = '0;
      end else if (active) begin
         if (phase == PH_LAST) begin
            phase_d = '0;
            if (col == COL_LAST) begin
               active_d = 1'b0;
               col_d    = '0;
            end else begin
               col_d = col + COL_W'(1);
            end
         end else begin
            phase_d = phase + PH_W'(1);
         end
      end
      idx    = COL_LAST - col_d;
      r1_d   = active_d & upper_d[idx];
      r2_d   = active_d & lower_d[idx];
      pclk_d = active_d && (phase_d >= PH_RISE);
      done_d = active_d && (col_d == COL_LAST) && (phase_d == PH_LAST);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         upper      <= '0;
         lower      <= '0;
         col        <= '0;
         phase      <= '0;
         active     <= 1'b0;
         r1         <= 1'b0;
         r2         <= 1'b0;
         pclk       <= 1'b0;
         shift_done <= 1'b0;
      end else begin
         upper      <= upper_d;
         lower      <= lower_d;
         col        <= col_d;
         phase      <= phase_d;
         active     <= active_d;
         r1         <= r1_d;
         r2         <= r2_d;
         pclk       <= pclk_d;
         shift_done <= done_d;
      end
   end

endmodule

// File: rtl/led_scan_driver.sv
// 1/32-scan HUB75 panel driver: fetches row pairs from the framebuffer, shifts, latches and displays them.
module led_scan_driver
   import led_panel_pkg::*;
#(
   parameter int unsigned CLK_DIV   = 2,
   parameter int unsigned ON_CYCLES = 256
) (
   input  logic               sys_clock,
   input  logic               reset,
   input  logic               enable,
   led_scan_driver_if.master  fb,
   output logic               panel_r1,
   output logic               panel_r2,
   output logic               panel_clk,
   output logic               panel_lat,
   output logic               panel_oe_n,
   output logic [ROW_W-1:0]   panel_addr,
   output logic               frame_done
);

   localparam int unsigned CNT_MAX = (ON_CYCLES > CLK_DIV) ?
                                     ((ON_CYCLES > 3) ? ON_CYCLES : 3) :
                                     ((CLK_DIV > 3) ? CLK_DIV : 3);
   localparam int unsigned CNT_W   = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(2);
   localparam logic [CNT_W-1:0] LAT_LAST   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
   localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(SCAN_ROWS - 1);

   scan_state_e         state, state_d;
   logic [CNT_W-1:0]    cnt, cnt_d;
   logic [ROW_W-1:0]    row, row_d;
   logic                done_d;
   logic                rd_en_d;
   logic [FB_ROW_W-1:0] rd_row_d;
   logic                lat_d, oe_n_d;
   logic [ROW_W-1:0]    addr_d;
   logic                load_hi, load_lo;
   logic                shift_done;

   // Read data arrives one cycle after each strobe, so captures trail the strobes by one.
   assign load_hi = (state == ST_FETCH) && (cnt == CNT_W'(1));
   assign load_lo = (state == ST_FETCH) && (cnt == FETCH_LAST);

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      row_d   = row;
      done_d  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enable) begin
               state_d = ST_FETCH;
               cnt_d   = '0;
            end
         end
         ST_FETCH: begin
            if (cnt == FETCH_LAST) begin
               state_d = ST_SHIFT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         ST_SHIFT: begin
            if (shift_done) begin
               state_d = ST_BLANK;
            end
         end
         ST_BLANK: begin
            state_d = ST_LATCH;
            cnt_d   = '0;
         end
         ST_LATCH: begin
            if (cnt == LAT_LAST) begin
               state_d = ST_DISPLAY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         ST_DISPLAY: begin
            if (cnt == ON_LAST) begin
               cnt_d   = '0;
               row_d   = row + ROW_W'(1);
               done_d  = (row == ROW_LAST);
               state_d = enable ? ST_FETCH : ST_IDLE;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Registered outputs follow the state being entered.
      rd_en_d  = (state_d == ST_FETCH) && (cnt_d < FETCH_LAST);
      rd_row_d = rd_en_d ? {cnt_d[0], row_d} : fb.fb_rd_row;
      lat_d    = (state_d == ST_LATCH);
      oe_n_d   = (state_d != ST_DISPLAY);
      addr_d   = (state_d == ST_BLANK) ? row_d : panel_addr;
   end

   always_ff @(posedge sys_clock) begin
      if (reset) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         row          <= '0;
         fb.fb_rd_en  <= 1'b0;
         fb.fb_rd_row <= '0;
         panel_lat    <= 1'b0;
         panel_oe_n   <= 1'b1;
         panel_addr   <= '0;
         frame_done   <= 1'b0;
      end else begin
         state        <= state_d;
         cnt          <= cnt_d;
         row          <= row_d;
         fb.fb_rd_en  <= rd_en_d;
         fb.fb_rd_row <= rd_row_d;
         panel_lat    <= lat_d;
         panel_oe_n   <= oe_n_d;
         panel_addr   <= addr_d;
         frame_done   <= done_d;
      end
   end

   scan_shifter #(
      .CLK_DIV (CLK_DIV)
   ) u_shifter (
      .clk        (sys_clock),
      .reset      (reset),
      .load_hi    (load_hi),
      .load_lo    (load_lo),
      .data       (fb.fb_rd_data),
      .r1         (panel_r1),
      .r2         (panel_r2),
      .pclk       (panel_clk),
      .shift_done (shift_done)
   );

endmodule

// File: tb/tb_led_scan_driver.sv
// Randomised bench for led_scan_driver against a per-row timeline model of the panel scan.
module tb_led_scan_driver;
   import led_panel_pkg::*;

   localparam int unsigned CD = 2;
   localparam int unsigned ON = 256;
   localparam int SH0  = 3;
   localparam int SHN  = 2 * CD * COLS;
   localparam int BLK  = SH0 + SHN;
   localparam int LAT0 = BLK + 1;
   localparam int DSP0 = LAT0 + CD;
   localparam int P    = DSP0 + ON;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       r1, r2, pclk, lat, oe_n, frame_done;
   logic [4:0] addr;

   led_scan_driver_if fb ();

   led_scan_driver #(.CLK_DIV(CD), .ON_CYCLES(ON)) dut (
      .sys_clock  (clk),
      .reset      (reset),
      .enable     (enable),
      .fb         (fb),
      .panel_r1   (r1),
      .panel_r2   (r2),
      .panel_clk  (pclk),
      .panel_lat  (lat),
      .panel_oe_n (oe_n),
      .panel_addr (addr),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] mem [64];
   bit          edits_on = 1'b0;

   // timeline model state
   bit          m_active = 1'b0;
   int          m_rel = 0;
   int          m_row = 0;
   logic [4:0]  m_addr = '0;
   logic        m_fd = 1'b0;
   logic [63:0] m_up = '0, m_lo = '0;

   // event monitors
   int          cyc = 0;
   int          t_row = -1;
   int          t_frame = -1;
   int          edges = 0;
   int          lat_len = 0;
   int          fd_count = 0;
   int          en_rises = 0;
   bit          was_rst = 1'b1;
   logic        prev_clk = 1'b0, prev_oe_n = 1'b1, prev_lat = 1'b0, prev_en = 1'b0;
   logic [5:0]  prev_row = '0;
   logic [63:0] cap1 = '0, cap2 = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic tick();
      logic [17:0] got, expv;
      logic        e_en, e_r1, e_r2, e_clk, e_lat, e_oe_n, in_sh;
      logic [5:0]  e_row, ci;
      int          s;
      @(posedge clk);
      m_fd    = 1'b0;
      was_rst = reset;
      if (reset) begin
         m_active = 1'b0; m_row = 0; m_addr = '0; m_rel = 0; t_frame = -1;
      end else if (!m_active) begin
         if (enable) begin m_active = 1'b1; m_rel = 0; end
      end else if (m_rel == P - 1) begin
         m_fd  = (m_row == 31);
         m_row = (m_row + 1) % 32;
         if (enable) m_rel = 0;
         else begin m_active = 1'b0; t_frame = -1; end
      end else begin
         m_rel++;
      end
      if (m_active && m_rel == BLK) m_addr = 5'(m_row);

      @(negedge clk);
      cyc++;
      if (m_active && m_rel == 1) m_up = mem[6'(m_row)];
      if (m_active && m_rel == 2) m_lo = mem[6'(m_row + 32)];

      e_en   = m_active && (m_rel < 2);
      e_row  = {m_rel == 1, 5'(m_row)};
      in_sh  = m_active && (m_rel >= SH0) && (m_rel < BLK);
      e_clk  = 1'b0; e_r1 = 1'b0; e_r2 = 1'b0;
      if (in_sh) begin
         s     = m_rel - SH0;
         e_clk = (s % (2 * CD)) >= CD;
         ci    = 6'(63 - s / (2 * CD));
         e_r1  = m_up[ci];
         e_r2  = m_lo[ci];
      end
      e_lat  = m_active && (m_rel >= LAT0) && (m_rel < DSP0);
      e_oe_n = !(m_active && (m_rel >= DSP0));
      expv = {e_en, e_en ? e_row : 6'd0, e_r1, e_r2, e_clk, e_lat, e_oe_n, m_addr, m_fd};
      got  = {fb.fb_rd_en, fb.fb_rd_en ? fb.fb_rd_row : 6'd0, in_sh ? r1 : 1'b0,
              in_sh ? r2 : 1'b0, pclk, lat, oe_n, addr, frame_done};
      check("cyc", 64'(got), 64'(expv));

      if (pclk && !prev_clk) begin
         edges++;
         cap1 = {cap1[62:0], r1};
         cap2 = {cap2[62:0], r2};
      end
      if (lat && !prev_lat) begin
         check("edges", 64'(edges), 64'(64));
         check("row_r1", cap1, m_up);
         check("row_r2", cap2, m_lo);
         check("lat_oe_n", 64'(oe_n), 64'(1));
         lat_len = 0;
      end
      if (lat) lat_len++;
      if (!lat && prev_lat && !was_rst) check("lat_len", 64'(lat_len), 64'(CD));
      if (oe_n && !prev_oe_n && !was_rst && t_row >= 0)
         check("period", 64'(cyc - t_row), 64'(P));
      if (frame_done) begin
         fd_count++;
         if (t_frame >= 0) check("frame_time", 64'(cyc - t_frame), 64'(32 * P));
      end
      if (fb.fb_rd_en && !prev_en) begin
         en_rises++;
         t_row = cyc;
         edges = 0;
         if (fb.fb_rd_row == 6'd0) t_frame = cyc;
      end

      fb.fb_rd_data = prev_en ? mem[prev_row] : {$urandom, $urandom};
      prev_en   = fb.fb_rd_en;
      prev_row  = fb.fb_rd_row;
      prev_clk  = pclk;
      prev_lat  = lat;
      prev_oe_n = oe_n;
      if (edits_on && $urandom_range(15) == 0) mem[6'($urandom_range(63))] = {$urandom, $urandom};
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_en"},   64'(fb.fb_rd_en), 64'(0));
      check({pfx, "_row"},  64'(fb.fb_rd_row), 64'(0));
      check({pfx, "_r1"},   64'(r1), 64'(0));
      check({pfx, "_r2"},   64'(r2), 64'(0));
      check({pfx, "_clk"},  64'(pclk), 64'(0));
      check({pfx, "_lat"},  64'(lat), 64'(0));
      check({pfx, "_oe_n"}, 64'(oe_n), 64'(1));
      check({pfx, "_addr"}, 64'(addr), 64'(0));
      check({pfx, "_fd"},   64'(frame_done), 64'(0));
   endtask

   initial begin
      int n;
      int base;
      fb.fb_rd_data = '0;
      for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom};
      mem[0]  = 64'h8000_0000_0000_0001;
      mem[32] = 64'h0;

      reset = 1'b1; enable = 1'b0;
      repeat (3) tick();
      check_reset_outputs("rst");
      reset = 1'b0;
      repeat (4) tick();

      // first row: fetch order, marker pattern, full frame and wrap
      enable = 1'b1;
      n = 0;
      while (!fb.fb_rd_en && n < 20) begin tick(); n++; end
      check("start_to", 64'(n < 20), 64'(1));
      check("fetch0_row", 64'(fb.fb_rd_row), 64'(0));
      tick();
      check("fetch1_row", 64'(fb.fb_rd_row), 64'(32));
      edits_on = 1'b1;
      n = 0;
      while (fd_count == 0 && n < 32 * P + 50) begin tick(); n++; end
      check("frame_done_n", 64'(fd_count), 64'(1));
      check("wrap_en", 64'(fb.fb_rd_en), 64'(1));
      check("wrap_row", 64'(fb.fb_rd_row), 64'(0));

      // enable dropped mid-shift of row 5
      n = 0;
      while (!(m_active && m_row == 5 && m_rel == SH0 + 100) && n < 7 * P) begin tick(); n++; end
      check("row5_to", 64'(n < 7 * P), 64'(1));
      enable = 1'b0;
      base = en_rises;
      repeat (P + 300) tick();
      check("idle_no_fetch", 64'(en_rises - base), 64'(0));
      check("idle_oe_n", 64'(oe_n), 64'(1));
      enable = 1'b1;
      n = 0;
      while (!fb.fb_rd_en && n < 20) begin tick(); n++; end
      check("resume_row", 64'(fb.fb_rd_row), 64'(6));

      // reset asserted in display of row 10
      n = 0;
      while (!(m_active && m_row == 10 && m_rel == DSP0 + 20) && n < 6 * P) begin tick(); n++; end
      check("disp_oe_n", 64'(oe_n), 64'(0));
      reset = 1'b1;
      tick();
      check_reset_outputs("mid_rst");
      reset = 1'b0;
      n = 0;
      while (!fb.fb_rd_en && n < 20) begin tick(); n++; end
      check("restart_row", 64'(fb.fb_rd_row), 64'(0));

      // random enable toggling
      repeat (4000) begin
         if ($urandom_range(127) == 0) enable = ~enable;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
